// File: rtl/dbus_sram_responder_if.sv
// Data-bus handshake between the pipeline memory stage (master) and a
// memory responder (slave): request carries valid/addr/size/strobe/data.
interface dbus_sram_responder_if;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_sram_responder.sv
// Single-ported word RAM answering dbus requests after a fixed LATENCY.
// Optional out-of-range detection enabled by defining DBUS_RESP_RANGE_CHECK_EN.
module dbus_sram_responder #(
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  dbus_sram_responder_if.slave  bus,
  output logic                  oob
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] laddr;
  logic [63:0] ldata;
  logic [7:0]  lstrb;
  logic [2:0]  lsize;
  logic        rspok;
  logic [63:0] rspdata;

  logic [63:0] mem [DEPTH];

  logic [63:0] aaddr;
  logic [63:0] adata;
  logic [7:0]  astrb;
  logic [63:0] offs;
  logic [AW-1:0] idx;
  logic        commit;
  logic        inrange;
  logic        unused_size;

  assign unused_size = ^lsize;

  // With LATENCY==1 the RAM access happens on the accept edge, so the
  // access fields come straight from the request while IDLE.
  always_comb begin
    aaddr = laddr;
    adata = ldata;
    astrb = lstrb;
    if (state == IDLE) begin
      aaddr = bus.dreq.addr;
      adata = bus.dreq.data;
      astrb = bus.dreq.strobe;
    end
    offs   = aaddr - BASE;
    idx    = AW'(offs >> 3);
    commit = !reset &&
             ((state == IDLE && bus.dreq.valid && LATENCY == 1) ||
              (state == BUSY && cnt == 4'd1));
`ifdef DBUS_RESP_RANGE_CHECK_EN
    inrange = (aaddr >= BASE) && (aaddr < BASE + 64'(DEPTH) * 64'd8);
`else
    inrange = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rspok   <= 1'b0;
      rspdata <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dreq.valid) begin
            laddr <= bus.dreq.addr;
            ldata <= bus.dreq.data;
            lstrb <= bus.dreq.strobe;
            lsize <= bus.dreq.size;
            cnt   <= 4'(LATENCY - 1);
            state <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          rspok   <= 1'b0;
          rspdata <= 64'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        rspok   <= 1'b1;
        rspdata <= (astrb == 8'd0 && inrange) ? mem[idx] : 64'd0;
      end
    end
  end

  // Reset gates commit, so an abandoned write never reaches the RAM.
  always_ff @(posedge clk) begin
    if (commit && inrange) begin
      for (int i = 0; i < 8; i++) begin
        if (astrb[i]) mem[idx][8*i +: 8] <= adata[8*i +: 8];
      end
    end
  end

`ifdef DBUS_RESP_RANGE_CHECK_EN
  logic oobq;

  always_ff @(posedge clk) begin
    if (reset) begin
      oobq <= 1'b0;
    end else if (commit) begin
      oobq <= !inrange;
    end else if (state == RESP) begin
      oobq <= 1'b0;
    end
  end

  assign oob = oobq;
`else
  assign oob = 1'b0;
`endif

  assign bus.dresp = {rspok, rspok, rspdata};

endmodule
